// File: rtl/datapath_pkg.sv
// Shared datapath-control definitions: default IR geometry, field offsets
// for the default geometry, and the decoder FSM state type.
package datapath_pkg;

  localparam int IR_W  = 32;
  localparam int OPW   = 5;
  localparam int SELW  = 4;
  localparam int NREGS = 2 ** SELW;

  // Field LSB positions for the default geometry (opcode at the MSBs, then Ra, Rb, Rc)
  localparam int RA_LSB = IR_W - OPW - SELW;
  localparam int RB_LSB = RA_LSB - SELW;
  localparam int RC_LSB = RB_LSB - SELW;
  localparam int C_W    = IR_W - OPW - 2 * SELW;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } state_e;

endpackage

// File: rtl/reg_select_decoder_onehot_decode.sv
// Combinational register-select to one-hot enable decoder.
module onehot_decode #(
  parameter int SELW = 4
) (
  input  logic [SELW-1:0]      i_sel,
  input  logic                 i_en,
  output logic [2**SELW-1:0]   o_onehot
);

  // Drive exactly one bit when enabled, all zeros otherwise
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/reg_select_decoder.sv
// Registered register-select decoder: latches Ra/Rb/Rc/C from the IR and
// turns the chosen field into one-hot write/read enables, with R0-as-base
// zeroing, a sign-extended constant and a sticky multi-select flag.
module reg_select_decoder #(
  parameter int IR_W = datapath_pkg::IR_W,
  parameter int OPW  = datapath_pkg::OPW,
  parameter int SELW = datapath_pkg::SELW
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [IR_W-1:0]      ir,
  input  logic                 ir_load,
  input  logic                 gra,
  input  logic                 grb,
  input  logic                 grc,
  input  logic                 rin,
  input  logic                 rout,
  input  logic                 ba_out,
  output logic [2**SELW-1:0]   r_in,
  output logic [2**SELW-1:0]   r_out,
  output logic                 r0_zero,
  output logic [IR_W-1:0]      c_sext,
  output logic                 valid,
  output logic                 conflict
);

  import datapath_pkg::*;

  localparam int NR    = 2 ** SELW;
  localparam int RA_LO = IR_W - OPW - SELW;
  localparam int RB_LO = RA_LO - SELW;
  localparam int RC_LO = RB_LO - SELW;
  localparam int CW    = IR_W - OPW - 2 * SELW;

  // Sign-extend the constant field to the full IR width
  function automatic logic [IR_W-1:0] sext_c(input logic [CW-1:0] c);
    return {{(IR_W - CW){c[CW-1]}}, c};
  endfunction

  state_e           r_state;
  logic [SELW-1:0]  r_ra;
  logic [SELW-1:0]  r_rb;
  logic [SELW-1:0]  r_rc;
  logic [IR_W-1:0]  r_csext;
  logic [NR-1:0]    r_wen;
  logic [NR-1:0]    r_ren;
  logic             r_r0z;
  logic             r_conflict;

  logic [SELW-1:0]  w_sel;
  logic             w_sel_vld;
  logic             w_multi;
  logic [NR-1:0]    w_wen;
  logic [NR-1:0]    w_ren;
  logic             w_unused_opcode;

  // The opcode bits are not decoded here
  assign w_unused_opcode = ^ir[IR_W-1 -: OPW];

  // Priority field select: Ra over Rb over Rc, nothing when none requested
  always_comb begin
    w_sel     = '0;
    w_sel_vld = 1'b0;
    if (gra) begin
      w_sel     = r_ra;
      w_sel_vld = 1'b1;
    end else if (grb) begin
      w_sel     = r_rb;
      w_sel_vld = 1'b1;
    end else if (grc) begin
      w_sel     = r_rc;
      w_sel_vld = 1'b1;
    end
  end

  assign w_multi = (gra & grb) | (gra & grc) | (grb & grc);

  onehot_decode #(.SELW(SELW)) u_dec_in (
    .i_sel    (w_sel),
    .i_en     (w_sel_vld & rin),
    .o_onehot (w_wen)
  );

  onehot_decode #(.SELW(SELW)) u_dec_out (
    .i_sel    (w_sel),
    .i_en     (w_sel_vld & (rout | ba_out)),
    .o_onehot (w_ren)
  );

  // Field latch; a same-edge select still decodes with the old fields
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_csext <= '0;
    end else if (ir_load) begin
      r_ra    <= ir[RA_LO +: SELW];
      r_rb    <= ir[RB_LO +: SELW];
      r_rc    <= ir[RC_LO +: SELW];
      r_csext <= sext_c(ir[CW-1:0]);
    end
  end

  // FSM with registered enables: nothing is driven until a load has been seen
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= EMPTY;
      r_wen   <= '0;
      r_ren   <= '0;
      r_r0z   <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          r_wen <= '0;
          r_ren <= '0;
          r_r0z <= 1'b0;
          if (ir_load) r_state <= VALID;
        end
        VALID: begin
          r_wen <= w_wen;
          r_ren <= w_ren;
          r_r0z <= ba_out & w_sel_vld & (w_sel == '0);
        end
        default: begin
          r_state <= EMPTY;
          r_wen   <= '0;
          r_ren   <= '0;
          r_r0z   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky record of any cycle with more than one field select raised
  always_ff @(posedge clk or posedge clr) begin
    if (clr)          r_conflict <= 1'b0;
    else if (w_multi) r_conflict <= 1'b1;
  end

  assign r_in     = r_wen;
  assign r_out    = r_ren;
  assign r0_zero  = r_r0z;
  assign c_sext   = r_csext;
  assign valid    = (r_state == VALID);
  assign conflict = r_conflict;

endmodule

// File: tb/tb_reg_select_decoder.sv
// Scoreboard bench for reg_select_decoder: directed scenarios followed by
// random traffic, predicted by a behavioural model of the field/decode rules.
module tb_reg_select_decoder;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = '0;
  logic        ir_load = 1'b0;
  logic        gra = 1'b0, grb = 1'b0, grc = 1'b0;
  logic        rin = 1'b0, rout = 1'b0, ba_out = 1'b0;
  logic [15:0] r_in, r_out;
  logic        r0_zero, valid, conflict;
  logic [31:0] c_sext;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [15:0] wen;
    logic [15:0] ren;
    logic        r0z;
    logic        vld;
    logic        conf;
    logic [31:0] cs;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int unsigned m_ra, m_rb, m_rc;
  logic [31:0] m_c;
  bit          m_loaded;
  bit          m_conf;

  reg_select_decoder dut (
    .clk      (clk),
    .clr      (clr),
    .ir       (ir),
    .ir_load  (ir_load),
    .gra      (gra),
    .grb      (grb),
    .grc      (grc),
    .rin      (rin),
    .rout     (rout),
    .ba_out   (ba_out),
    .r_in     (r_in),
    .r_out    (r_out),
    .r0_zero  (r0_zero),
    .c_sext   (c_sext),
    .valid    (valid),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ir(input int unsigned ra, input int unsigned rb,
                                        input logic [31:0] c19);
    return (32'd1 << 27) | (32'(ra) << 23) | (32'(rb) << 19) | (c19 & 32'h7FFFF);
  endfunction

  task automatic model_reset();
    m_ra = 0; m_rb = 0; m_rc = 0; m_c = '0; m_loaded = 0; m_conf = 0;
  endtask

  // Apply one cycle of inputs and queue the response expected after the next edge
  task automatic drive(input logic [31:0] v_ir, input bit ld, input bit a, input bit b,
                       input bit c, input bit wi, input bit ro, input bit ba);
    exp_t        e;
    int          cnt;
    int unsigned sel;
    bit          has;
    logic [15:0] oh;
    @(negedge clk);
    ir = v_ir; ir_load = ld; gra = a; grb = b; grc = c;
    rin = wi; rout = ro; ba_out = ba;
    cnt = int'(a) + int'(b) + int'(c);
    has = (cnt > 0);
    sel = a ? m_ra : (b ? m_rb : (c ? m_rc : 0));
    oh  = 16'd1 << sel;
    e.wen = (m_loaded && has && wi) ? oh : 16'd0;
    e.ren = (m_loaded && has && (ro || ba)) ? oh : 16'd0;
    e.r0z = m_loaded && has && ba && (sel == 0);
    if (cnt >= 2) m_conf = 1;
    e.conf = m_conf;
    if (ld) begin
      m_loaded = 1;
      m_ra = (v_ir >> 23) % 16;
      m_rb = (v_ir >> 19) % 16;
      m_rc = (v_ir >> 15) % 16;
      m_c  = v_ir % 32'h80000;
      if (v_ir[18]) m_c = m_c - 32'h80000;
    end
    e.vld = m_loaded;
    e.cs  = m_c;
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(ir, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Pulse clr between edges and check that every output drops at once
  task automatic do_reset();
    @(negedge clk);
    #2;
    sb.delete();
    ir_load = 0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; ba_out = 0;
    clr = 1;
    #1;
    chk("rst_r_in", 32'(r_in), 0);
    chk("rst_r_out", 32'(r_out), 0);
    chk("rst_r0_zero", 32'(r0_zero), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_conflict", 32'(conflict), 0);
    chk("rst_c_sext", c_sext, 0);
    @(negedge clk);
    #2;
    clr = 0;
    model_reset();
  endtask

  // Monitor: compare every DUT response against the oldest queued prediction
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("r_in", 32'(r_in), 32'(e.wen));
        chk("r_out", 32'(r_out), 32'(e.ren));
        chk("r0_zero", 32'(r0_zero), 32'(e.r0z));
        chk("valid", 32'(valid), 32'(e.vld));
        chk("conflict", 32'(conflict), 32'(e.conf));
        chk("c_sext", c_sext, e.cs);
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk("init_r_in", 32'(r_in), 0);
    chk("init_r_out", 32'(r_out), 0);
    chk("init_valid", 32'(valid), 0);
    chk("init_c_sext", c_sext, 0);
    #12;
    clr = 0;

    // Select with nothing latched yet produces nothing
    drive(32'h0, 0, 0, 1, 0, 0, 1, 0);
    idle();

    // Ra=5, Rb=3, Rc=0 then write-select Ra
    drive(32'h0A980005, 1, 0, 0, 0, 0, 0, 0);
    drive(32'h0A980005, 0, 1, 0, 0, 1, 0, 0);
    idle();
    idle();

    // Multi-select: Ra wins, conflict becomes sticky
    drive(32'h0A980005, 0, 1, 1, 0, 0, 1, 0);
    idle();
    drive(32'h0A980005, 0, 0, 0, 1, 1, 1, 0);
    idle();

    // Rb=0 as base register, then a plain read of R0
    drive(mk_ir(5, 0, 32'h0), 1, 0, 0, 0, 0, 0, 0);
    drive(ir, 0, 0, 1, 0, 0, 0, 1);
    drive(ir, 0, 0, 1, 0, 0, 1, 0);
    idle();

    // Constant sign extension
    drive(mk_ir(1, 2, 32'h40000), 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("sext_neg", c_sext, 32'hFFFC0000);
    drive(mk_ir(1, 2, 32'h3FFFF), 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("sext_pos", c_sext, 32'h0003FFFF);

    // Same-edge load uses old Ra=5; the following select sees Ra=7
    drive(mk_ir(5, 3, 32'h0), 1, 0, 0, 0, 0, 0, 0);
    drive(mk_ir(7, 3, 32'h0), 1, 1, 0, 0, 1, 0, 0);
    drive(ir, 0, 1, 0, 0, 1, 0, 0);
    do_reset();

    // After reset a select without a load stays silent
    drive(mk_ir(9, 4, 32'h0), 0, 1, 0, 0, 1, 1, 0);
    idle();

    // Random traffic with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rir;
      if (i == 200) do_reset();
      rir = $urandom;
      drive(rir, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) == 0));
    end
    idle();

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
